// File: rtl/spi_master_if.sv
// spi_master_if -- host bus seen by the SPI master.
//   addr     : register select (bus A1..A0)
//   _sel     : active-low register select from the address decode
//   rw       : 1 = read, 0 = write
//   dataIn   : bus write data
//   dataOut  : register read data, combinational on addr
// The master modport is the CPU/bus side; the slave modport is the SPI block.
interface spi_master_if;
    logic [1:0] addr;
    logic       _sel;
    logic       rw;
    logic [7:0] dataIn;
    logic [7:0] dataOut;

    modport master (output addr, output _sel, output rw, output dataIn, input dataOut);
    modport slave  (input addr, input _sel, input rw, input dataIn, output dataOut);
endinterface

// File: rtl/spi_master.sv
// spi_master -- byte-wide mode-0 SPI master behind a small 4-register bus window.
// Ports:
//   fclk      : sole clock
//   _reset    : asynchronous active-low reset
//   bus       : spi_master_if.slave (addr, _sel, rw, dataIn, dataOut)
//   spi_clk   : SCK, idles low, MISO sampled on its rising edge
//   spi_mosi  : serial out, MSB first, holds its last value while idle
//   spi_miso  : serial in
//   spi_cs    : chip select, driven straight from CTRL bit 0
//   busy      : high while a byte is shifting
// Register map: 0 DATA, 1 CTRL/STATUS {busy, overrun, 5'b0, cs}, 2 DIV, 3 reads 0x00.
// Build option: define SPI_DIVIDER_EN to make DIV a writable half-period count;
// otherwise SCK runs at fclk/2 and address 2 reads as zero.
module spi_master (
    input  logic        fclk,
    input  logic        _reset,
    spi_master_if.slave bus,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic       wr_pend_q, wr_pend_d;
    logic [1:0] cap_addr_q, cap_addr_d;
    logic [7:0] cap_data_q, cap_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] h_q, h_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       cs_q, cs_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;
    logic       sel_rise_s, commit_s, start_s;
    logic [7:0] div_rd_s;
    logic [7:0] rd_s;

`ifdef SPI_DIVIDER_EN
    logic [7:0] div_q, div_d;
    assign div_rd_s = div_q;
`else
    assign div_rd_s = 8'h00;
`endif

    // Bus write capture/commit, register writes and the shift FSM next state.
    always_comb begin
        sel_s1_d   = bus._sel;
        sel_s2_d   = sel_s1_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        wr_pend_d  = wr_pend_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        h_d        = h_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        start_s    = 1'b0;
`ifdef SPI_DIVIDER_EN
        div_d      = div_q;
`endif

        // Synchronised _sel going high closes the access; the commit below
        // uses the values captured on earlier edges of the low period.
        sel_rise_s = sel_s1_q && !sel_s2_q;
        commit_s   = sel_rise_s && wr_pend_q;

        if (!sel_s2_q && !bus.rw) begin
            cap_addr_d = bus.addr;
            cap_data_d = bus.dataIn;
        end else begin
            cap_addr_d = cap_addr_q;
        end

        if (sel_rise_s) begin
            wr_pend_d = 1'b0;
        end else if (!sel_s2_q && !bus.rw) begin
            wr_pend_d = 1'b1;
        end else begin
            wr_pend_d = wr_pend_q;
        end

        if (commit_s) begin
            case (cap_addr_q)
                2'd0: begin
                    if (state_q == ST_IDLE) begin
                        start_s = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                2'd1: begin
                    cs_d = cap_data_q[0];
                    if (cap_data_q[6]) begin
                        ovr_d = 1'b0;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end
                2'd2: begin
`ifdef SPI_DIVIDER_EN
                    div_d = cap_data_q;
`endif
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_LOW;
                    tx_d      = cap_data_q;
                    mosi_d    = cap_data_q[7];
                    bit_cnt_d = 3'd0;
                    div_cnt_d = 8'd0;
                    sck_d     = 1'b0;
                    busy_d    = 1'b1;
                    h_d       = div_rd_s;    // DIV is latched once per byte
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (div_cnt_q == h_q) begin
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[6:0], spi_miso};
                    div_cnt_d = 8'd0;
                    state_d   = ST_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_cnt_q == h_q) begin
                    sck_d     = 1'b0;
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        rd_data_d = rx_q;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = {tx_q[6:0], 1'b0};
                        mosi_d    = tx_q[6];
                        state_d   = ST_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and register update; reset also aborts any byte in flight.
    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= ST_IDLE;
            sel_s1_q   <= 1'b1;
            sel_s2_q   <= 1'b1;
            wr_pend_q  <= 1'b0;
            cap_addr_q <= 2'd0;
            cap_data_q <= 8'h00;
            bit_cnt_q  <= 3'd0;
            div_cnt_q  <= 8'd0;
            h_q        <= 8'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            rd_data_q  <= 8'hFF;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef SPI_DIVIDER_EN
            div_q      <= 8'h09;
`endif
        end else begin
            state_q    <= state_d;
            sel_s1_q   <= sel_s1_d;
            sel_s2_q   <= sel_s2_d;
            wr_pend_q  <= wr_pend_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            h_q        <= h_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
`ifdef SPI_DIVIDER_EN
            div_q      <= div_d;
`endif
        end
    end

    // Register read mux; the bus drives this only while selected.
    always_comb begin
        rd_s = 8'h00;
        case (bus.addr)
            2'd0:    rd_s = rd_data_q;
            2'd1:    rd_s = {busy_q, ovr_q, 5'b00000, cs_q};
            2'd2:    rd_s = div_rd_s;
            default: rd_s = 8'h00;
        endcase
    end

    assign bus.dataOut = rd_s;
    assign spi_clk     = sck_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs      = cs_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
    logic fclk;
    logic _reset;
    logic spi_clk, spi_mosi, spi_miso, spi_cs, busy;
    logic loopback, miso_drv;
    int   checks = 0;
    int   failures = 0;

    spi_master_if bus ();

    spi_master dut (
        .fclk     (fclk),
        ._reset   (_reset),
        .bus      (bus.slave),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs   (spi_cs),
        .busy     (busy)
    );

    assign spi_miso = loopback ? spi_mosi : miso_drv;

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full bus write cycle; returns just after the commit edge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge fclk);
        bus.addr   = a;
        bus.dataIn = d;
        bus.rw     = 1'b0;
        bus._sel   = 1'b0;
        repeat (3) @(negedge fclk);
        bus._sel = 1'b1;
        @(posedge fclk);
        @(posedge fclk);
        #1;
        bus.rw = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.addr = a;
        bus.rw   = 1'b1;
        #1;
        d = bus.dataOut;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge fclk);
            #1;
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // One byte: MOSI bits seen at SCK rises must spell tx, MISO either loops
    // back or presents rxpat MSB first, byte time is 16*(h+1) fclk cycles.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] rxpat,
                            input logic lb, input int h, input string tag);
        int cyc = 0;
        int rises = 0;
        int t_rise = 0;
        int t_fall = 0;
        int falls = 0;
        logic [7:0] mo = 8'h00;
        logic [7:0] rd;
        logic pclk;
        loopback = lb;
        miso_drv = rxpat[7];
        bus_write(2'd0, tx);
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        pclk = spi_clk;
        while (busy === 1'b1 && cyc < 5000) begin
            @(posedge fclk);
            #1;
            cyc++;
            if (spi_clk === 1'b1 && pclk === 1'b0) begin
                mo = {mo[6:0], spi_mosi};
                if (rises == 0) t_rise = cyc;
                rises++;
                if (rises < 8) miso_drv = rxpat[7 - rises];
            end
            if (spi_clk === 1'b0 && pclk === 1'b1) begin
                if (falls == 0) t_fall = cyc;
                falls++;
            end
            pclk = spi_clk;
        end
        chk({tag, "_cycles"}, cyc, 16 * (h + 1));
        chk({tag, "_half_period"}, t_fall - t_rise, h + 1);
        chk({tag, "_rises"}, rises, 8);
        chk({tag, "_mosi_byte"}, {24'd0, mo}, {24'd0, tx});
        bus_read(2'd0, rd);
        chk({tag, "_data_rd"}, {24'd0, rd}, {24'd0, (lb ? tx : rxpat)});
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] tx, rxp;
        int n;
        _reset     = 1'b0;
        bus._sel   = 1'b1;
        bus.rw     = 1'b1;
        bus.addr   = 2'd0;
        bus.dataIn = 8'h00;
        loopback   = 1'b0;
        miso_drv   = 1'b0;
        repeat (3) @(negedge fclk);
        _reset = 1'b1;
        @(negedge fclk);

        bus_read(2'd1, rd);
        chk("rst_ctrl", {24'd0, rd}, 32'h01);
        bus_read(2'd0, rd);
        chk("rst_data", {24'd0, rd}, 32'hFF);
        bus_read(2'd3, rd);
        chk("rst_rsvd", {24'd0, rd}, 32'h00);
        chk("rst_cs", {31'd0, spi_cs}, 32'd1);
        chk("rst_sck", {31'd0, spi_clk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

`ifdef SPI_DIVIDER_EN
        bus_read(2'd2, rd);
        chk("rst_div", {24'd0, rd}, 32'h09);
        run_xfer(8'hFF, 8'h00, 1'b0, 9, "div9");
        bus_write(2'd2, 8'h00);
        bus_read(2'd2, rd);
        chk("div_wr0", {24'd0, rd}, 32'h00);
`else
        bus_read(2'd2, rd);
        chk("rst_div_fixed", {24'd0, rd}, 32'h00);
        run_xfer(8'hFF, 8'h00, 1'b0, 0, "ff_zero");
`endif

        run_xfer(8'hA5, 8'h00, 1'b1, 0, "loop_a5");
        chk("idle_mosi_hold", {31'd0, spi_mosi}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            tx  = 8'($urandom);
            rxp = 8'($urandom);
            run_xfer(tx, rxp, 1'($urandom_range(0, 1)), 0, "rnd");
        end

        // Second DATA write lands mid-byte: ignored, overrun flagged.
        loopback = 1'b1;
        bus_write(2'd0, 8'h3C);
        bus_write(2'd0, 8'hC3);
        bus_read(2'd1, rd);
        chk("ovr_ctrl_busy", {24'd0, rd}, 32'hC1);
        wait_idle("ovr_idle");
        bus_read(2'd0, rd);
        chk("ovr_data", {24'd0, rd}, 32'h3C);
        bus_read(2'd1, rd);
        chk("ovr_ctrl_idle", {24'd0, rd}, 32'h41);
        bus_write(2'd1, 8'h41);
        bus_read(2'd1, rd);
        chk("ovr_clear", {24'd0, rd}, 32'h01);

        bus_write(2'd1, 8'h00);
        chk("cs_low", {31'd0, spi_cs}, 32'd0);
        bus_read(2'd1, rd);
        chk("cs_ctrl", {24'd0, rd}, 32'h00);

        // Reset during bit 4 of a byte.
        bus_write(2'd0, 8'h5A);
        n = 0;
        while (n < 5000) begin
            @(posedge fclk);
            #1;
            if (spi_clk === 1'b1) break;
            n++;
        end
        repeat (7) @(posedge fclk);
        #1;
        _reset = 1'b0;
        #1;
        chk("abort_sck", {31'd0, spi_clk}, 32'd0);
        chk("abort_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("abort_cs", {31'd0, spi_cs}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        bus_read(2'd0, rd);
        chk("abort_data", {24'd0, rd}, 32'hFF);
        @(negedge fclk);
        _reset = 1'b1;
        @(negedge fclk);

`ifdef SPI_DIVIDER_EN
        bus_read(2'd2, rd);
        chk("abort_div", {24'd0, rd}, 32'h09);
        bus_write(2'd2, 8'h01);
        bus_read(2'd2, rd);
        chk("div_wr1", {24'd0, rd}, 32'h01);
        run_xfer(8'($urandom), 8'h96, 1'b0, 1, "div1");
`else
        bus_write(2'd2, 8'h20);
        bus_read(2'd2, rd);
        chk("div_ignored", {24'd0, rd}, 32'h00);
        run_xfer(8'($urandom), 8'h96, 1'b0, 0, "fixed_after_div");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
